pipe_hazard_ctrl: RTL and testbench
===================================

// Module: pipe_hazard_ctrl
// PURPOSE
//  Central sequencer for the 5-stage SimpleRisc pipeline (IF, OF, EX, MA, WB). Drives load-enable
//  and bubble controls for the PC and the four pipeline latches IF_OF, OF_EX, EX_MA, MA_WB.
//  Resolves data hazards, taken-branch flushes and the multi-cycle data-memory handshake in MA.
//  Counts stall cycles for performance debug.
// PARAMETERS
//  MEM_TIMEOUT  15  WAIT-state cycles before Mem_Err is raised (1..255)
//  FWD_EN       0   0: full interlock on EX/MA/WB writers; 1: forwarding present, interlock only load-use in EX
// PORTS
//  Clk            in   1  pipeline clock; all state updates on posedge
//  Rst_n          in   1  reset; one clock, synchronous, active-low
//  Of_Src1        in   4  OF-stage first source register
//  Of_Src2        in   4  OF-stage second source register (rd for st)
//  Of_Use1/Of_Use2 in  1  corresponding source is actually read
//  Ex_Valid, Ma_Valid, Wb_Valid in 1  stage holds a real (non-bubble) instruction
//  Ex_Rd, Ma_Rd, Wb_Rd  in 4  destination register per stage (r15 for call already resolved)
//  Ex_IsWb, Ma_IsWb, Wb_IsWb in 1  stage writes the register file
//  Ex_IsLd        in   1  EX instruction is ld
//  Ex_BranchTaken in   1  EX resolved a taken branch/call/ret (valid only with Ex_Valid)
//  Ma_IsLd, Ma_IsSt in 1  MA instruction accesses data memory
//  Mem_Ready      in   1  data memory completes the current access this cycle
//  Mem_Req        out  1  data memory access request
//  Pc_En, IfOf_En, OfEx_En, ExMa_En, MaWb_En out 1  latch load enables
//  Pc_Sel         out  1  1: PC loads Branch_Target; 0: PC+4
//  IfOf_Bubble, OfEx_Bubble, MaWb_Bubble out 1  latch loads a NOP (Valid=0) instead of upstream data
//  Mem_Err        out  1  sticky memory-timeout error
//  Stall_Cycles   out 16  saturating count of cycles with Pc_En=0 (after reset)
// BEHAVIOUR
//  Reset (Rst_n=0 at posedge): FSM->IDLE, wait counter=0, Mem_Err=0, Stall_Cycles=0. While Rst_n=0
//   all *_En=0, all *_Bubble=1, Mem_Req=0, Pc_Sel=0. Reset mid-access abandons it; no retry.
//  Outputs are combinational from FSM state + inputs; effect is at the next posedge (0-cycle latency).
//  MA FSM states: IDLE, WAIT, ERR.
//   IDLE: mem_op = Ma_Valid&(Ma_IsLd|Ma_IsSt). mem_op -> Mem_Req=1; Mem_Ready same cycle -> stay IDLE
//    (zero-wait); else -> WAIT, counter=1.
//   WAIT: Mem_Req=1, counter++. Mem_Ready -> IDLE (access done this cycle). counter==MEM_TIMEOUT
//    with no Mem_Ready -> ERR. Mem_Ready on the timeout cycle wins (-> IDLE).
//   ERR: Mem_Err=1, Mem_Req=0, all *_En=0; exits only on reset.
//  mem_stall = mem_op & ~Mem_Ready (IDLE or WAIT). Priority: ERR > mem_stall > branch flush > data hazard.
//   mem_stall: Pc/IfOf/OfEx/ExMa_En=0, MaWb_En=1 with MaWb_Bubble=1 (WB never repeats an instruction).
//   branch (Ex_Valid&Ex_BranchTaken, no mem_stall): Pc_En=1, Pc_Sel=1, all latches enabled,
//    IfOf_Bubble=1, OfEx_Bubble=1. A branch coincident with mem_stall is held (EX frozen) and
//    applied on the cycle the stall releases. Branch overrides a coincident data hazard.
//   data hazard: match(s) = Use_s & stage_valid & stage_IsWb & Rd==Src_s.
//    FWD_EN=0: any match in EX, MA or WB. FWD_EN=1: match in EX with Ex_IsLd only.
//    Action: Pc_En=0, IfOf_En=0, OfEx_En=1 with OfEx_Bubble=1, ExMa_En=MaWb_En=1.
//  No event: all *_En=1, all *_Bubble=0, Pc_Sel=0.
//  Stall_Cycles += 1 each cycle Pc_En=0 and Rst_n=1; saturates at 0xFFFF.
// STRUCTURE
//  Package pipe_ctrl_pkg: MA FSM state enum, REG_W=4 localparam, stall-cause priority encoding.
//  Sub-module pipe_hazard_detect: combinational source/destination comparator producing the
//   data-hazard flag (FWD_EN-parameterised); FSM, priority mux and counter stay in the top.
// TESTING
//  Reset: Rst_n=0 two cycles with random inputs -> all En=0, Bubble=1, Mem_Req=0, Stall_Cycles=0.
//  FWD_EN=0, Ex_Rd=3 IsWb, Of_Src1=3 Use1 -> Pc_En=0, OfEx_Bubble=1; hazard moves to MA, WB ->
//   3 stall cycles total, Stall_Cycles=3.
//  FWD_EN=1, ld r5 in EX, Of_Src2=5 -> exactly 1 bubble; non-ld writer r5 -> no stall.
//  Ma_IsLd, Mem_Ready after 4 cycles -> Mem_Req high 5 cycles, upstream frozen 4, MaWb_Bubble=1 x4.
//  Ex_BranchTaken during 2-cycle mem stall -> Pc_Sel=1 and IfOf/OfEx bubbles only on release cycle.
//  MEM_TIMEOUT=15, Mem_Ready never -> Mem_Err=1 after 16th Mem_Req cycle, stays 1; Rst_n=0 clears.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared types and stall-cause priority for the pipeline sequencer
package pipe_ctrl_pkg;

    localparam int REG_W = 4;

    typedef enum logic [1:0] {
        MA_IDLE,
        MA_WAIT,
        MA_ERR
    } ma_state_e;

    typedef enum logic [2:0] {
        CAUSE_NONE,
        CAUSE_HAZARD,
        CAUSE_BRANCH,
        CAUSE_MEM,
        CAUSE_ERR
    } stall_cause_e;

    // Highest-priority event wins: a dead memory beats everything, a frozen MA beats a flush.
    function automatic stall_cause_e stall_cause(
        input logic err,
        input logic mem_stall,
        input logic branch,
        input logic hazard
    );
        if (err) begin
            return CAUSE_ERR;
        end else if (mem_stall) begin
            return CAUSE_MEM;
        end else if (branch) begin
            return CAUSE_BRANCH;
        end else if (hazard) begin
            return CAUSE_HAZARD;
        end
        return CAUSE_NONE;
    endfunction

endpackage

// File: rtl/pipe_hazard_detect.sv
// rtl/pipe_hazard_detect.sv - OF-source versus EX/MA/WB-destination comparator for RAW hazards
module pipe_hazard_detect
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned FWD_EN = 0
) (
    input  logic [REG_W-1:0] of_src1,
    input  logic [REG_W-1:0] of_src2,
    input  logic             of_use1,
    input  logic             of_use2,
    input  logic             ex_valid,
    input  logic             ex_is_wb,
    input  logic             ex_is_ld,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ma_valid,
    input  logic             ma_is_wb,
    input  logic [REG_W-1:0] ma_rd,
    input  logic             wb_valid,
    input  logic             wb_is_wb,
    input  logic [REG_W-1:0] wb_rd,
    output logic             hazard
);

    function automatic logic stage_hit(
        input logic             use1,
        input logic [REG_W-1:0] src1,
        input logic             use2,
        input logic [REG_W-1:0] src2,
        input logic             valid,
        input logic             is_wb,
        input logic [REG_W-1:0] rd
    );
        return valid & is_wb & ((use1 & (rd == src1)) | (use2 & (rd == src2)));
    endfunction

    logic ex_hit;
    logic ma_hit;
    logic wb_hit;

    always_comb begin
        ex_hit = stage_hit(of_use1, of_src1, of_use2, of_src2, ex_valid, ex_is_wb, ex_rd);
        ma_hit = stage_hit(of_use1, of_src1, of_use2, of_src2, ma_valid, ma_is_wb, ma_rd);
        wb_hit = stage_hit(of_use1, of_src1, of_use2, of_src2, wb_valid, wb_is_wb, wb_rd);
        // With bypass paths only a load still in EX cannot supply its result in time.
        if (FWD_EN != 0) begin
            hazard = ex_hit & ex_is_ld;
        end else begin
            hazard = ex_hit | ma_hit | wb_hit;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - 5-stage pipeline sequencer: latch enables, bubbles, MA memory FSM, stall counter
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned FWD_EN      = 0
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic [REG_W-1:0] Of_Src1,
    input  logic [REG_W-1:0] Of_Src2,
    input  logic             Of_Use1,
    input  logic             Of_Use2,
    input  logic             Ex_Valid,
    input  logic             Ma_Valid,
    input  logic             Wb_Valid,
    input  logic [REG_W-1:0] Ex_Rd,
    input  logic [REG_W-1:0] Ma_Rd,
    input  logic [REG_W-1:0] Wb_Rd,
    input  logic             Ex_IsWb,
    input  logic             Ma_IsWb,
    input  logic             Wb_IsWb,
    input  logic             Ex_IsLd,
    input  logic             Ex_BranchTaken,
    input  logic             Ma_IsLd,
    input  logic             Ma_IsSt,
    input  logic             Mem_Ready,
    output logic             Mem_Req,
    output logic             Pc_En,
    output logic             IfOf_En,
    output logic             OfEx_En,
    output logic             ExMa_En,
    output logic             MaWb_En,
    output logic             Pc_Sel,
    output logic             IfOf_Bubble,
    output logic             OfEx_Bubble,
    output logic             MaWb_Bubble,
    output logic             Mem_Err,
    output logic [15:0]      Stall_Cycles
);

    localparam logic [7:0] TIMEOUT_CNT = 8'(MEM_TIMEOUT);

    ma_state_e    state_q, state_d;
    logic [7:0]   wait_cnt_q, wait_cnt_d;
    logic [15:0]  stall_cnt_q, stall_cnt_d;

    logic         hazard;
    logic         mem_op;
    logic         mem_busy;
    logic         mem_stall;
    logic         branch;
    stall_cause_e cause;

    pipe_hazard_detect #(
        .FWD_EN (FWD_EN)
    ) u_detect (
        .of_src1  (Of_Src1),
        .of_src2  (Of_Src2),
        .of_use1  (Of_Use1),
        .of_use2  (Of_Use2),
        .ex_valid (Ex_Valid),
        .ex_is_wb (Ex_IsWb),
        .ex_is_ld (Ex_IsLd),
        .ex_rd    (Ex_Rd),
        .ma_valid (Ma_Valid),
        .ma_is_wb (Ma_IsWb),
        .ma_rd    (Ma_Rd),
        .wb_valid (Wb_Valid),
        .wb_is_wb (Wb_IsWb),
        .wb_rd    (Wb_Rd),
        .hazard   (hazard)
    );

    always_comb begin
        mem_op    = Ma_Valid & (Ma_IsLd | Ma_IsSt);
        // Once waiting, MA is frozen, so the access stays in flight until Mem_Ready.
        mem_busy  = ((state_q == MA_IDLE) & mem_op) | (state_q == MA_WAIT);
        mem_stall = mem_busy & ~Mem_Ready;
        branch    = Ex_Valid & Ex_BranchTaken;
        cause     = stall_cause(state_q == MA_ERR, mem_stall, branch, hazard);
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            MA_IDLE: begin
                if (mem_op & ~Mem_Ready) begin
                    state_d    = MA_WAIT;
                    wait_cnt_d = 8'd1;
                end
            end
            MA_WAIT: begin
                if (Mem_Ready) begin
                    state_d    = MA_IDLE;
                    wait_cnt_d = 8'd0;
                end else if (wait_cnt_q == TIMEOUT_CNT) begin
                    state_d = MA_ERR;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            MA_ERR: begin
                state_d = MA_ERR;
            end
            default: begin
                state_d    = MA_IDLE;
                wait_cnt_d = 8'd0;
            end
        endcase
    end

    always_comb begin
        Mem_Req     = mem_busy;
        Pc_En       = 1'b1;
        IfOf_En     = 1'b1;
        OfEx_En     = 1'b1;
        ExMa_En     = 1'b1;
        MaWb_En     = 1'b1;
        Pc_Sel      = 1'b0;
        IfOf_Bubble = 1'b0;
        OfEx_Bubble = 1'b0;
        MaWb_Bubble = 1'b0;
        case (cause)
            CAUSE_ERR: begin
                Mem_Req     = 1'b0;
                Pc_En       = 1'b0;
                IfOf_En     = 1'b0;
                OfEx_En     = 1'b0;
                ExMa_En     = 1'b0;
                MaWb_En     = 1'b0;
                IfOf_Bubble = 1'b1;
                OfEx_Bubble = 1'b1;
                MaWb_Bubble = 1'b1;
            end
            CAUSE_MEM: begin
                // WB still advances, but only with a NOP so no instruction retires twice.
                Pc_En       = 1'b0;
                IfOf_En     = 1'b0;
                OfEx_En     = 1'b0;
                ExMa_En     = 1'b0;
                MaWb_Bubble = 1'b1;
            end
            CAUSE_BRANCH: begin
                Pc_Sel      = 1'b1;
                IfOf_Bubble = 1'b1;
                OfEx_Bubble = 1'b1;
            end
            CAUSE_HAZARD: begin
                Pc_En       = 1'b0;
                IfOf_En     = 1'b0;
                OfEx_Bubble = 1'b1;
            end
            default: begin
                Pc_Sel = 1'b0;
            end
        endcase
        if (!Rst_n) begin
            Mem_Req     = 1'b0;
            Pc_En       = 1'b0;
            IfOf_En     = 1'b0;
            OfEx_En     = 1'b0;
            ExMa_En     = 1'b0;
            MaWb_En     = 1'b0;
            Pc_Sel      = 1'b0;
            IfOf_Bubble = 1'b1;
            OfEx_Bubble = 1'b1;
            MaWb_Bubble = 1'b1;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (!Pc_En && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state_q     <= MA_IDLE;
            wait_cnt_q  <= 8'd0;
            stall_cnt_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign Mem_Err      = (state_q == MA_ERR);
    assign Stall_Cycles = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - bench for pipe_hazard_ctrl: directed scenarios plus random traffic against a reference model
module tb_pipe_hazard_ctrl;

    logic       Clk = 1'b0;
    logic       Rst_n;
    logic [3:0] Of_Src1, Of_Src2, Ex_Rd, Ma_Rd, Wb_Rd;
    logic       Of_Use1, Of_Use2, Ex_Valid, Ma_Valid, Wb_Valid;
    logic       Ex_IsWb, Ma_IsWb, Wb_IsWb, Ex_IsLd, Ex_BranchTaken;
    logic       Ma_IsLd, Ma_IsSt, Mem_Ready;

    // {Mem_Req, Pc_En, IfOf_En, OfEx_En, ExMa_En, MaWb_En, Pc_Sel, IfOf_Bubble, OfEx_Bubble, MaWb_Bubble, Mem_Err}
    wire [10:0] ctrl0, ctrl1;
    wire [15:0] stall0, stall1;

    int errors = 0;
    int checks = 0;

    int fwd_p [2] = '{0, 1};
    int to_p  [2] = '{15, 4};
    bit m_err [2];
    int m_pend[2];
    int m_stall[2];
    bit pc_en_exp[2];

    always #5 Clk = ~Clk;

    pipe_hazard_ctrl #(.MEM_TIMEOUT(15), .FWD_EN(0)) u_dut0 (
        .Clk(Clk), .Rst_n(Rst_n), .Of_Src1(Of_Src1), .Of_Src2(Of_Src2), .Of_Use1(Of_Use1), .Of_Use2(Of_Use2),
        .Ex_Valid(Ex_Valid), .Ma_Valid(Ma_Valid), .Wb_Valid(Wb_Valid), .Ex_Rd(Ex_Rd), .Ma_Rd(Ma_Rd), .Wb_Rd(Wb_Rd),
        .Ex_IsWb(Ex_IsWb), .Ma_IsWb(Ma_IsWb), .Wb_IsWb(Wb_IsWb), .Ex_IsLd(Ex_IsLd), .Ex_BranchTaken(Ex_BranchTaken),
        .Ma_IsLd(Ma_IsLd), .Ma_IsSt(Ma_IsSt), .Mem_Ready(Mem_Ready),
        .Mem_Req(ctrl0[10]), .Pc_En(ctrl0[9]), .IfOf_En(ctrl0[8]), .OfEx_En(ctrl0[7]), .ExMa_En(ctrl0[6]),
        .MaWb_En(ctrl0[5]), .Pc_Sel(ctrl0[4]), .IfOf_Bubble(ctrl0[3]), .OfEx_Bubble(ctrl0[2]),
        .MaWb_Bubble(ctrl0[1]), .Mem_Err(ctrl0[0]), .Stall_Cycles(stall0)
    );

    pipe_hazard_ctrl #(.MEM_TIMEOUT(4), .FWD_EN(1)) u_dut1 (
        .Clk(Clk), .Rst_n(Rst_n), .Of_Src1(Of_Src1), .Of_Src2(Of_Src2), .Of_Use1(Of_Use1), .Of_Use2(Of_Use2),
        .Ex_Valid(Ex_Valid), .Ma_Valid(Ma_Valid), .Wb_Valid(Wb_Valid), .Ex_Rd(Ex_Rd), .Ma_Rd(Ma_Rd), .Wb_Rd(Wb_Rd),
        .Ex_IsWb(Ex_IsWb), .Ma_IsWb(Ma_IsWb), .Wb_IsWb(Wb_IsWb), .Ex_IsLd(Ex_IsLd), .Ex_BranchTaken(Ex_BranchTaken),
        .Ma_IsLd(Ma_IsLd), .Ma_IsSt(Ma_IsSt), .Mem_Ready(Mem_Ready),
        .Mem_Req(ctrl1[10]), .Pc_En(ctrl1[9]), .IfOf_En(ctrl1[8]), .OfEx_En(ctrl1[7]), .ExMa_En(ctrl1[6]),
        .MaWb_En(ctrl1[5]), .Pc_Sel(ctrl1[4]), .IfOf_Bubble(ctrl1[3]), .OfEx_Bubble(ctrl1[2]),
        .MaWb_Bubble(ctrl1[1]), .Mem_Err(ctrl1[0]), .Stall_Cycles(stall1)
    );

    function automatic bit model_hazard(input int d);
        logic [3:0] rd  [3] = '{Ex_Rd, Ma_Rd, Wb_Rd};
        bit         vl  [3] = '{Ex_Valid, Ma_Valid, Wb_Valid};
        bit         wbk [3] = '{Ex_IsWb, Ma_IsWb, Wb_IsWb};
        logic [3:0] src [2] = '{Of_Src1, Of_Src2};
        bit         us  [2] = '{Of_Use1, Of_Use2};
        for (int s = 0; s < 2; s++) begin
            for (int k = 0; k < 3; k++) begin
                if (us[s] && vl[k] && wbk[k] && rd[k] == src[s]) begin
                    if (fwd_p[d] == 0 || (k == 0 && Ex_IsLd)) return 1'b1;
                end
            end
        end
        return 1'b0;
    endfunction

    function automatic logic [10:0] model_ctrl(input int d);
        bit req;
        req = (m_pend[d] > 0) || (Ma_Valid && (Ma_IsLd || Ma_IsSt));
        if (!Rst_n)                        return {1'b0, 5'b00000, 1'b0, 3'b111, m_err[d]};
        if (m_err[d])                      return {1'b0, 5'b00000, 1'b0, 3'b111, 1'b1};
        if (req && !Mem_Ready)             return {1'b1, 5'b00001, 1'b0, 3'b001, 1'b0};
        if (Ex_Valid && Ex_BranchTaken)    return {req,  5'b11111, 1'b1, 3'b110, 1'b0};
        if (model_hazard(d))               return {req,  5'b00111, 1'b0, 3'b010, 1'b0};
        return {req, 5'b11111, 1'b0, 3'b000, 1'b0};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check(input string tag);
        logic [10:0] e, obs;
        logic [15:0] sobs;
        #1;
        for (int d = 0; d < 2; d++) begin
            e            = model_ctrl(d);
            pc_en_exp[d] = e[9];
            obs          = (d == 0) ? ctrl0 : ctrl1;
            sobs         = (d == 0) ? stall0 : stall1;
            checks++;
            assert (obs === e) else begin
                errors++;
                $error("FAIL %s dut%0d ctrl: observed %b expected %b", tag, d, obs, e);
            end
            checks++;
            assert (sobs === 16'(m_stall[d])) else begin
                errors++;
                $error("FAIL %s dut%0d stall_cycles: observed %0d expected %0d", tag, d, sobs, m_stall[d]);
            end
        end
    endtask

    task automatic tick();
        bit req;
        @(posedge Clk);
        for (int d = 0; d < 2; d++) begin
            if (!Rst_n) begin
                m_err[d] = 0; m_pend[d] = 0; m_stall[d] = 0;
            end else begin
                if (!pc_en_exp[d] && m_stall[d] < 65535) m_stall[d]++;
                req = (m_pend[d] > 0) || (Ma_Valid && (Ma_IsLd || Ma_IsSt));
                if (!m_err[d] && req) begin
                    if (Mem_Ready)                m_pend[d] = 0;
                    else if (m_pend[d] == to_p[d]) begin m_err[d] = 1; m_pend[d] = 0; end
                    else                          m_pend[d]++;
                end
            end
        end
        @(negedge Clk);
    endtask

    task automatic clear_inputs();
        Of_Src1 = 0; Of_Src2 = 0; Ex_Rd = 0; Ma_Rd = 0; Wb_Rd = 0;
        Of_Use1 = 0; Of_Use2 = 0; Ex_Valid = 0; Ma_Valid = 0; Wb_Valid = 0;
        Ex_IsWb = 0; Ma_IsWb = 0; Wb_IsWb = 0; Ex_IsLd = 0; Ex_BranchTaken = 0;
        Ma_IsLd = 0; Ma_IsSt = 0; Mem_Ready = 0;
    endtask

    task automatic rand_inputs();
        Of_Src1 = 4'($urandom_range(0, 3)); Of_Src2 = 4'($urandom_range(0, 3));
        Ex_Rd = 4'($urandom_range(0, 3)); Ma_Rd = 4'($urandom_range(0, 3)); Wb_Rd = 4'($urandom_range(0, 3));
        Of_Use1 = 1'($urandom); Of_Use2 = 1'($urandom);
        Ex_Valid = 1'($urandom); Ma_Valid = 1'($urandom); Wb_Valid = 1'($urandom);
        Ex_IsWb = 1'($urandom); Ma_IsWb = 1'($urandom); Wb_IsWb = 1'($urandom);
        Ex_IsLd = 1'($urandom); Ex_BranchTaken = ($urandom_range(0, 3) == 0);
        Ma_IsLd = ($urandom_range(0, 2) == 0); Ma_IsSt = ($urandom_range(0, 3) == 0);
        Mem_Ready = ($urandom_range(0, 2) != 0);
    endtask

    task automatic do_reset();
        Rst_n = 1'b0;
        rand_inputs();
        tick();
        rand_inputs();
        check("reset");
        chk("reset_en0", ctrl0[9:5], 0);
        chk("reset_bub0", ctrl0[3:1], 7);
        tick();
        Rst_n = 1'b1;
        clear_inputs();
    endtask

    int req_cnt, bub_cnt;

    initial begin
        clear_inputs();
        Rst_n = 1'b0;
        do_reset();

        // RAW on r3 walking EX -> MA -> WB: three interlock cycles without forwarding
        Of_Src1 = 3; Of_Use1 = 1; Ex_Valid = 1; Ex_Rd = 3; Ex_IsWb = 1;
        check("haz_ex");
        chk("haz_ex_pc_en", ctrl0[9], 0);
        chk("haz_ex_ofex_bub", ctrl0[2], 1);
        tick();
        Ex_Valid = 0; Ex_IsWb = 0; Ma_Valid = 1; Ma_Rd = 3; Ma_IsWb = 1;
        check("haz_ma");
        tick();
        Ma_Valid = 0; Ma_IsWb = 0; Wb_Valid = 1; Wb_Rd = 3; Wb_IsWb = 1;
        check("haz_wb");
        tick();
        clear_inputs();
        check("haz_done");
        chk("haz_stall0", stall0, 3);
        chk("haz_stall1", stall1, 0);
        tick();

        // load-use with forwarding: one bubble; a non-load writer never stalls
        do_reset();
        Of_Src2 = 5; Of_Use2 = 1; Ex_Valid = 1; Ex_Rd = 5; Ex_IsWb = 1; Ex_IsLd = 1;
        check("ldu_ex");
        chk("ldu_pc_en", ctrl1[9], 0);
        chk("ldu_bub", ctrl1[2], 1);
        tick();
        Ex_Valid = 0; Ex_IsWb = 0; Ex_IsLd = 0;
        Ma_Valid = 1; Ma_Rd = 5; Ma_IsWb = 1; Ma_IsLd = 1; Mem_Ready = 1;
        check("ldu_ma");
        chk("ldu_ma_pc_en", ctrl1[9], 1);
        tick();
        clear_inputs();
        Of_Src2 = 5; Of_Use2 = 1; Ex_Valid = 1; Ex_Rd = 5; Ex_IsWb = 1;
        check("alu_fwd");
        chk("alu_fwd_pc_en", ctrl1[9], 1);
        tick();
        clear_inputs();
        check("ldu_done");
        chk("ldu_stall1", stall1, 1);
        tick();

        // load with four wait cycles
        do_reset();
        Ma_Valid = 1; Ma_IsLd = 1;
        req_cnt = 0; bub_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            Mem_Ready = (i == 4);
            check("mem_wait");
            req_cnt += int'(ctrl0[10]);
            bub_cnt += int'(ctrl0[1]);
            tick();
        end
        clear_inputs();
        check("mem_done");
        chk("mem_req_cycles", req_cnt, 5);
        chk("mem_bubbles", bub_cnt, 4);
        chk("mem_stall_cnt", stall0, 4);
        tick();

        // taken branch held behind a two-cycle memory stall
        do_reset();
        Ma_Valid = 1; Ma_IsSt = 1; Ex_Valid = 1; Ex_BranchTaken = 1;
        for (int i = 0; i < 3; i++) begin
            Mem_Ready = (i == 2);
            check("br_mem");
            chk("br_pc_sel", ctrl0[4], (i == 2) ? 1 : 0);
            chk("br_ifof_bub", ctrl0[3], (i == 2) ? 1 : 0);
            tick();
        end
        clear_inputs();

        // memory timeout: error after the 16th request cycle, sticky until reset
        do_reset();
        Ma_Valid = 1; Ma_IsSt = 1;
        for (int i = 0; i < 16; i++) begin
            check("timeout");
            if (i == 15) chk("timeout_not_yet", ctrl0[0], 0);
            tick();
        end
        check("timeout_err");
        chk("timeout_err_set", ctrl0[0], 1);
        chk("timeout_req_off", ctrl0[10], 0);
        tick();
        Mem_Ready = 1; Ma_Valid = 0;
        check("timeout_sticky");
        chk("timeout_still_err", ctrl0[0], 1);
        tick();
        do_reset();
        check("timeout_cleared");
        chk("timeout_cleared_err", ctrl0[0], 0);
        tick();

        // random traffic with occasional resets
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 59) == 0) begin
                do_reset();
            end
            rand_inputs();
            check("rand");
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
